// File: rtl/jk_cmd_sequencer_if.sv
// Command handshake between a JK stimulus source and jk_cmd_sequencer.
// One command carries the J/K code plus the hold count for how long to replay it.
interface jk_cmd_sequencer_if #(
    parameter int HOLD_W = 4
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_j;
    logic              cmd_k;
    logic [HOLD_W-1:0] cmd_hold;

    modport master (
        output cmd_valid,
        output cmd_j,
        output cmd_k,
        output cmd_hold,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_j,
        input  cmd_k,
        input  cmd_hold,
        output cmd_ready
    );
endinterface

// File: rtl/jk_cmd_sequencer.sv
// Queues JK commands and replays each on j/k for cmd_hold+1 cycles, then returns to the hold code.
// state | meaning
// IDLE  | no command driven, j=k=0, waiting for the FIFO to become non-empty
// DRIVE | replaying the loaded command; next one is chained in with no gap
module jk_cmd_sequencer #(
    parameter int DEPTH  = 4,
    parameter int HOLD_W = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    jk_cmd_sequencer_if.slave          cmd,
    output logic                       j,
    output logic                       k,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(DEPTH+1)-1:0] level
);
    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int ENT_W = HOLD_W + 2;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    typedef enum logic {
        IDLE,
        DRIVE
    } state_t;

    logic [ENT_W-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    state_t            state_q, state_d;
    logic [HOLD_W-1:0] cnt_q, cnt_d;
    logic              j_q, j_d, k_q, k_d;
    logic              busy_q, busy_d, done_q, done_d;
    logic              push, pop;
    logic [ENT_W-1:0]  head;

    assign cmd.cmd_ready = (level_q != FULL_LVL);
    assign push          = cmd.cmd_valid && cmd.cmd_ready;
    assign head          = mem_q[rd_ptr_q];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        j_d     = j_q;
        k_d     = k_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                j_d    = 1'b0;
                k_d    = 1'b0;
                busy_d = 1'b0;
                if (level_q != '0) begin
                    pop     = 1'b1;
                    j_d     = head[ENT_W-1];
                    k_d     = head[ENT_W-2];
                    cnt_d   = head[HOLD_W-1:0];
                    busy_d  = 1'b1;
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (level_q != '0) begin
                    pop   = 1'b1;
                    j_d   = head[ENT_W-1];
                    k_d   = head[ENT_W-2];
                    cnt_d = head[HOLD_W-1:0];
                end else begin
                    j_d     = 1'b0;
                    k_d     = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // Storage needs no reset: entries are only read behind a valid level.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem_q[wr_ptr_q] <= {cmd.cmd_j, cmd.cmd_k, cmd.cmd_hold};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            state_q  <= IDLE;
            cnt_q    <= '0;
            j_q      <= 1'b0;
            k_q      <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            j_q      <= j_d;
            k_q      <= k_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign j     = j_q;
    assign k     = k_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign level = level_q;
endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Self-checking bench for jk_cmd_sequencer: each accepted command is scheduled as a time
// interval [start, end) and every output is predicted from that schedule.
module tb_jk_cmd_sequencer;
    localparam int DEPTH  = 4;
    localparam int HOLD_W = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       dj, dk, dbusy, ddone;
    logic [2:0] dlevel;

    jk_cmd_sequencer_if #(.HOLD_W(HOLD_W)) cif ();

    jk_cmd_sequencer #(.DEPTH(DEPTH), .HOLD_W(HOLD_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .cmd   (cif),
        .j     (dj),
        .k     (dk),
        .busy  (dbusy),
        .done  (ddone),
        .level (dlevel)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n = 0;
    int last_end = 0;
    int ps[$];
    int st[$];
    int en[$];
    bit cj[$];
    bit ck[$];

    function automatic int model_level();
        int lv = 0;
        foreach (ps[i]) begin
            if (ps[i] <= n) lv++;
            if (st[i] <= n) lv--;
        end
        return lv;
    endfunction

    function automatic logic [7:0] exp_vec();
        int  lv = model_level();
        bit  ej = 0, ek = 0, eb = 0, ends = 0, starts = 0;
        foreach (ps[i]) begin
            if (st[i] <= n && n < en[i]) begin
                ej = cj[i];
                ek = ck[i];
                eb = 1'b1;
            end
            if (en[i] == n) ends = 1'b1;
            if (st[i] == n) starts = 1'b1;
        end
        return {ej, ek, eb, (ends && !starts), 3'(lv), (lv != DEPTH)};
    endfunction

    function automatic logic [7:0] obs_vec();
        return {dj, dk, dbusy, ddone, dlevel, cif.cmd_ready};
    endfunction

    task automatic cycle(input bit v, input bit jj, input bit kk, input int h, input bit r);
        bit acc;
        int s;
        cif.cmd_valid = v;
        cif.cmd_j     = jj;
        cif.cmd_k     = kk;
        cif.cmd_hold  = HOLD_W'(h);
        rst           = r;
        acc = v && !r && (model_level() != DEPTH);
        @(posedge clk);
        n++;
        #1;
        if (r) begin
            ps.delete(); st.delete(); en.delete(); cj.delete(); ck.delete();
            last_end = 0;
        end else if (acc) begin
            s = (n + 1 > last_end) ? n + 1 : last_end;
            ps.push_back(n); st.push_back(s); en.push_back(s + h + 1);
            cj.push_back(jj); ck.push_back(kk);
            last_end = s + h + 1;
        end
    endtask

    task automatic test_reset();
        cycle(1, 1, 1, 3, 1);
        cycle(0, 0, 0, 0, 1);
        checks++;
        if (obs_vec() !== 8'b0000_000_1) begin
            errors++;
            $display("FAIL reset_state got %b exp %b", obs_vec(), 8'b0000_000_1);
        end
        cycle(0, 0, 0, 0, 0);
        checks++;
        if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL reset_release cyc %0d got %b exp %b", n, obs_vec(), exp_vec());
        end
    endtask

    task automatic test_single();
        int dones = 0;
        int ones  = 0;
        cycle(1, 1, 0, 2, 0);
        for (int i = 0; i < 7; i++) begin
            cycle(0, 0, 0, 0, 0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL single cyc %0d got %b exp %b", n, obs_vec(), exp_vec());
            end
            dones += ddone;
            ones  += (dj && !dk);
        end
        checks++;
        if (dones !== 1 || ones !== 3) begin
            errors++;
            $display("FAIL single_count done %0d j_cycles %0d exp 1 and 3", dones, ones);
        end
    endtask

    task automatic test_back_to_back();
        int dones = 0;
        int bcyc  = 0;
        bit jv[4] = '{1, 0, 0, 1};
        bit kv[4] = '{0, 0, 1, 1};
        int hv[4] = '{0, 1, 0, 2};
        for (int i = 0; i < 4; i++) begin
            cycle(1, jv[i], kv[i], hv[i], 0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL b2b_push cyc %0d got %b exp %b", n, obs_vec(), exp_vec());
            end
            dones += ddone;
            bcyc  += dbusy;
        end
        for (int i = 0; i < 8; i++) begin
            cycle(0, 0, 0, 0, 0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL b2b_drain cyc %0d got %b exp %b", n, obs_vec(), exp_vec());
            end
            dones += ddone;
            bcyc  += dbusy;
        end
        checks++;
        if (dones !== 1 || bcyc !== 7) begin
            errors++;
            $display("FAIL b2b_count done %0d busy %0d exp 1 and 7", dones, bcyc);
        end
    endtask

    task automatic test_full();
        bit saw_full = 0;
        cycle(1, 1, 0, 15, 0);
        for (int i = 0; i < 8; i++) begin
            cycle(1, i[0], 1, i % 3, 0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL full_fill cyc %0d got %b exp %b", n, obs_vec(), exp_vec());
            end
            if (!cif.cmd_ready && dlevel == 3'd4) saw_full = 1;
        end
        for (int i = 0; i < 30; i++) begin
            cycle(0, 0, 0, 0, 0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL full_drain cyc %0d got %b exp %b", n, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (saw_full !== 1'b1) begin
            errors++;
            $display("FAIL full_seen got %b exp 1", saw_full);
        end
    endtask

    task automatic test_push_pop();
        bit pv[6] = '{1, 1, 1, 0, 0, 1};
        int hv[6] = '{3, 0, 0, 0, 0, 1};
        for (int i = 0; i < 6; i++) begin
            cycle(pv[i], i[0], i[1], hv[i], 0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL pushpop cyc %0d got %b exp %b", n, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (dlevel !== 3'd2) begin
            errors++;
            $display("FAIL pushpop_level got %0d exp 2", dlevel);
        end
        for (int i = 0; i < 10; i++) begin
            cycle(0, 0, 0, 0, 0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL pushpop_drain cyc %0d got %b exp %b", n, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_reset_mid();
        cycle(1, 1, 0, 7, 0);
        cycle(1, 0, 1, 7, 0);
        cycle(1, 1, 1, 7, 0);
        cycle(1, 1, 0, 7, 0);
        checks++;
        if (dlevel !== 3'd3 || dbusy !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pre level %0d busy %b exp 3 and 1", dlevel, dbusy);
        end
        cycle(1, 1, 1, 5, 1);
        checks++;
        if (obs_vec() !== 8'b0000_000_1) begin
            errors++;
            $display("FAIL rstmid_state got %b exp %b", obs_vec(), 8'b0000_000_1);
        end
        cycle(1, 0, 1, 1, 0);
        for (int i = 0; i < 5; i++) begin
            cycle(0, 0, 0, 0, 0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL rstmid_after cyc %0d got %b exp %b", n, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 2) != 0), 1'($urandom), 1'($urandom),
                  $urandom_range(0, 3), ($urandom_range(0, 80) == 0));
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random cyc %0d got %b exp %b", n, obs_vec(), exp_vec());
            end
        end
        for (int i = 0; i < 40; i++) cycle(0, 0, 0, 0, 0);
        checks++;
        if (obs_vec() !== 8'b0000_000_1) begin
            errors++;
            $display("FAIL random_idle got %b exp %b", obs_vec(), 8'b0000_000_1);
        end
    endtask

    task automatic test_latch();
        bit q  = 0;
        bit jv[5] = '{1, 0, 0, 0, 1};
        bit kv[5] = '{0, 0, 1, 0, 1};
        bit eq[5] = '{1, 1, 0, 0, 1};
        for (int i = 0; i < 8; i++) begin
            if (i < 5) cycle(1, jv[i], kv[i], 0, 0);
            else       cycle(0, 0, 0, 0, 0);
            if (dj && !dk)      q = 1'b1;
            else if (!dj && dk) q = 1'b0;
            else if (dj && dk)  q = ~q;
            if (i >= 1 && i <= 5) begin
                checks++;
                if (q !== eq[i-1] || obs_vec() !== exp_vec()) begin
                    errors++;
                    $display("FAIL latch step %0d q %b exp %b outs %b exp %b",
                             i, q, eq[i-1], obs_vec(), exp_vec());
                end
            end
        end
    endtask

    initial begin
        rst           = 1'b1;
        cif.cmd_valid = 1'b0;
        cif.cmd_j     = 1'b0;
        cif.cmd_k     = 1'b0;
        cif.cmd_hold  = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_full();
        test_push_pop();
        test_reset_mid();
        test_random();
        test_latch();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/jk_cmd_sequencer.md
Name: jk_cmd_sequencer

Overview:
- Upstream driver stage for the jk_latch block; produces its j and k inputs.
- Accepts JK commands over a valid/ready interface into a small FIFO.
- Replays each command on j/k for a programmed number of clk cycles.
- Returns to the hold code (j=0, k=0) when no work remains, so latch test sequences run autonomously instead of being hand-timed with delays.

Parameters:
DEPTH, 4, command FIFO entries; power of two, >= 2
HOLD_W, 4, width of per-command hold count

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
cmd_valid  input  1  command present on cmd_j/cmd_k/cmd_hold
cmd_ready  output  1  FIFO can accept a command this cycle
cmd_j  input  1  J value for command
cmd_k  input  1  K value for command
cmd_hold  input  HOLD_W  command drives j/k for cmd_hold+1 cycles
j  output  1  registered J to latch
k  output  1  registered K to latch
busy  output  1  a command is currently being driven
done  output  1  one-cycle pulse when last queued command finishes
level  output  $clog2(DEPTH+1)  FIFO occupancy

Behaviour:
- One clock domain (clk). rst is synchronous, active-high, sampled on the clk rising edge.
- Reset values:
  - j=0, k=0, busy=0, done=0, level=0
  - cmd_ready=1 (combinational from FIFO not full)
  - FSM=IDLE, hold counter=0
- FIFO:
  - Circular buffer with wr/rd pointers that wrap at DEPTH.
  - Push when cmd_valid && cmd_ready; store {cmd_j, cmd_k, cmd_hold}.
  - cmd_ready = (level != DEPTH). A push is refused when full even if a pop occurs in the same cycle.
  - Push and pop in the same cycle are allowed when not full: level unchanged, both pointers advance.
  - level = pushes minus pops; never exceeds DEPTH, never below 0.
  - cmd_j/cmd_k/cmd_hold are ignored when cmd_valid=0.
- FSM states IDLE, DRIVE:
  - IDLE:
    - j=k=0, busy=0.
    - If FIFO non-empty: pop head, load j/k/cnt from it, go DRIVE.
  - DRIVE:
    - busy=1; j/k hold the loaded values.
    - If cnt != 0: cnt decrements.
    - If cnt == 0 and FIFO non-empty: pop next entry and load it that same edge. Back-to-back, no hold-code gap, busy stays 1.
    - If cnt == 0 and FIFO empty: j=k=0, go IDLE, done=1 for exactly that next cycle.
- Latency:
  - Command pushed at edge N into an empty FIFO while IDLE is popped at edge N+1.
  - j/k are visible after edge N+1.
  - Each command occupies j/k for exactly cmd_hold+1 cycles. cmd_hold=0 gives 1 cycle; max is 2^HOLD_W cycles.
- j=1, k=1 (toggle) is a legal command and passes through unchanged. The sequencer does not interpret codes.
- done never asserts when leaving reset or while busy stays continuously high between commands.
- Reset mid-operation:
  - FIFO flushed (pointers and level = 0), current command abandoned.
  - j=k=0 next cycle, no done pulse.
  - Any push presented in the reset cycle is discarded.
- All outputs except cmd_ready are registered.

Test Plan:
- Reset then single command (j=1, k=0, hold=2), pushed at edge 0 → j=1, k=0 for cycles 1–3; j=k=0 from cycle 4; done=1 only in cycle 4; level returns to 0.
- Four commands pushed back-to-back: (1,0,h0), (0,0,h1), (0,1,h0), (1,1,h2) → j/k sequence 10 | 00,00 | 01 | 11,11,11 with no gaps; busy continuous; single done after last.
- Fill to DEPTH=4 while the first command holds 15 → cmd_ready=0 with level=4; 5th cmd_valid not accepted; cmd_ready rises the cycle after the next pop.
- Simultaneous push and pop at level=2 → level stays 2; pointer wrap past entry 3 returns correct data order.
- Assert rst mid-DRIVE with level=3 → next cycle j=k=0, busy=0, level=0, done=0; a new command after reset plays normally.
- Drive a jk_latch instance from j/k with hold=0 sequence set, hold, reset, hold, toggle → latch q/qb follow expected JK behaviour on each clk high phase.
